// File: rtl/trdb_filter.sv
// trdb_filter: per-instruction trace qualification (address ranges, stop-after-N) feeding trace_req_off.
// Optional privilege filtering is enabled by defining TRDB_FILTER_PRIV_EN (adds priv_i, cfg_priv_mask_i).
module trdb_filter #(
  parameter int ADDR_W     = 32,
  parameter int NUM_RANGES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         trace_enable_i,
  input  logic                         inst_valid_i,
  input  logic [ADDR_W-1:0]            iaddr_i,
  input  logic [NUM_RANGES-1:0]        cfg_range_en_i,
  input  logic [NUM_RANGES*ADDR_W-1:0] cfg_lo_i,
  input  logic [NUM_RANGES*ADDR_W-1:0] cfg_hi_i,
  input  logic [CNT_W-1:0]             cfg_stop_after_i,
`ifdef TRDB_FILTER_PRIV_EN
  input  logic [1:0]                   priv_i,
  input  logic [3:0]                   cfg_priv_mask_i,
`endif
  output logic                         qualified_o,
  output logic                         trace_req_off_o,
  output logic [CNT_W-1:0]             count_o,
  output logic [1:0]                   state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_TRACING = 2'd2,
    S_STOP    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_qual;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [NUM_RANGES-1:0] w_match;
  logic                  w_in_range;
  logic                  w_priv_ok;
  logic                  w_hit;
  logic [CNT_W:0]        w_cnt_inc;
  logic                  w_stop;

  always_comb begin
    w_match = '0;
    for (int k = 0; k < NUM_RANGES; k++) begin
      w_match[k] = cfg_range_en_i[k]
                && (cfg_lo_i[k*ADDR_W +: ADDR_W] <= iaddr_i)
                && (iaddr_i <= cfg_hi_i[k*ADDR_W +: ADDR_W]);
    end
  end

  // No range enabled means the address filter is bypassed.
  assign w_in_range = (cfg_range_en_i == '0) ? 1'b1 : |w_match;

`ifdef TRDB_FILTER_PRIV_EN
  assign w_priv_ok = cfg_priv_mask_i[priv_i];
`else
  assign w_priv_ok = 1'b1;
`endif

  assign w_hit = inst_valid_i && trace_enable_i && w_in_range && w_priv_ok
              && ((r_state == S_ARMED) || (r_state == S_TRACING));

  // One extra bit so count+1 cannot wrap before the threshold compare.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_stop    = w_hit && (cfg_stop_after_i != '0)
                  && (w_cnt_inc >= {1'b0, cfg_stop_after_i});

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!trace_enable_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = '0;
        end
        S_ARMED, S_TRACING: begin
          if (w_hit) begin
            if (r_cnt != '1) w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
            w_state_nxt = w_stop ? S_STOP : S_TRACING;
          end
        end
        default: w_state_nxt = S_STOP;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_qual  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qual  <= w_hit;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign qualified_o     = r_qual;
  assign trace_req_off_o = (r_state == S_STOP);
  assign count_o         = r_cnt;
  assign state_o         = r_state;

endmodule

// File: tb/tb_trdb_filter.sv
// Bench for trdb_filter: directed instruction streams, scoreboard of expected qualifications.
module tb_trdb_filter;
  localparam int ADDR_W = 32;
  localparam int NR     = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              trace_enable_i;
  logic              inst_valid_i;
  logic [ADDR_W-1:0] iaddr_i;
  logic [NR-1:0]     cfg_range_en_i;
  logic [NR*ADDR_W-1:0] cfg_lo_i;
  logic [NR*ADDR_W-1:0] cfg_hi_i;
  logic [CNT_W-1:0]  cfg_stop_after_i;
  logic              qualified_o;
  logic              trace_req_off_o;
  logic [CNT_W-1:0]  count_o;
  logic [1:0]        state_o;
`ifdef TRDB_FILTER_PRIV_EN
  logic [1:0]        priv_i;
  logic [3:0]        cfg_priv_mask_i;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cnt;
  logic [CNT_W:0] sb_q[$];  // {expected trace_req_off, expected count}

  always #5 clk = ~clk;

  trdb_filter #(.ADDR_W(ADDR_W), .NUM_RANGES(NR), .CNT_W(CNT_W)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .trace_enable_i(trace_enable_i),
    .inst_valid_i(inst_valid_i),
    .iaddr_i(iaddr_i),
    .cfg_range_en_i(cfg_range_en_i),
    .cfg_lo_i(cfg_lo_i),
    .cfg_hi_i(cfg_hi_i),
    .cfg_stop_after_i(cfg_stop_after_i),
`ifdef TRDB_FILTER_PRIV_EN
    .priv_i(priv_i),
    .cfg_priv_mask_i(cfg_priv_mask_i),
`endif
    .qualified_o(qualified_o),
    .trace_req_off_o(trace_req_off_o),
    .count_o(count_o),
    .state_o(state_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every qualified pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (qualified_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_qualified", 32'd1, 32'd0);
      end else begin
        logic [CNT_W:0] e;
        e = sb_q.pop_front();
        chk("qual_count", 32'(count_o), 32'(e[CNT_W-1:0]));
        chk("qual_req_off", 32'(trace_req_off_o), 32'(e[CNT_W]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input bit q, input bit req);
    inst_valid_i = 1'b1;
    iaddr_i      = a;
    if (q) begin
      exp_cnt++;
      sb_q.push_back({req, CNT_W'(exp_cnt)});
    end
    cyc();
    inst_valid_i = 1'b0;
  endtask

  task automatic set_range0(input logic [ADDR_W-1:0] lo, input logic [ADDR_W-1:0] hi);
    cfg_lo_i[ADDR_W-1:0] = lo;
    cfg_hi_i[ADDR_W-1:0] = hi;
  endtask

  initial begin
    logic [ADDR_W-1:0] t2_addr [4];
    bit                t2_q    [4];
    logic [ADDR_W-1:0] t4_addr [5];
    t2_addr = '{32'h0FFC, 32'h1000, 32'h10FF, 32'h1100};
    t2_q    = '{1'b0, 1'b1, 1'b1, 1'b0};
    t4_addr = '{32'h0800, 32'h1000, 32'h1800, 32'h2000, 32'h3000};

    rst_i = 1'b1; trace_enable_i = 1'b0; inst_valid_i = 1'b0; iaddr_i = '0;
    cfg_range_en_i = '0; cfg_lo_i = '0; cfg_hi_i = '0; cfg_stop_after_i = '0;
`ifdef TRDB_FILTER_PRIV_EN
    priv_i = 2'd3; cfg_priv_mask_i = 4'hF;
`endif
    exp_cnt = 0;
    cyc(); cyc();
    chk("rst_qual", 32'(qualified_o), 32'd0);
    chk("rst_req", 32'(trace_req_off_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    rst_i = 1'b0;

    // 1: bypass filter, 5 back-to-back instructions
    trace_enable_i = 1'b1;
    cyc();
    chk("t1_armed", 32'(state_o), 32'd1);
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) issue(32'h100 + 32'(4*i), 1'b1, 1'b0);
    chk("t1_state", 32'(state_o), 32'd2);
    chk("t1_count", 32'(count_o), 32'd5);
    chk("t1_req", 32'(trace_req_off_o), 32'd0);
    cyc();

    // 2: inclusive range bounds
    trace_enable_i = 1'b0; cyc();
    cfg_range_en_i = 2'b01; set_range0(32'h1000, 32'h10FF);
    trace_enable_i = 1'b1; cyc();
    exp_cnt = 0;
    chk("t2_count0", 32'(count_o), 32'd0);
    for (int i = 0; i < 4; i++) issue(t2_addr[i], t2_q[i], 1'b0);
    cyc();
    chk("t2_count", 32'(count_o), 32'd2);
    chk("t2_state", 32'(state_o), 32'd2);

    // 3: stop after 3
    cfg_stop_after_i = 16'd3;
    trace_enable_i = 1'b0; cyc();
    trace_enable_i = 1'b1; cyc();
    exp_cnt = 0;
    issue(32'h1000, 1'b1, 1'b0);
    issue(32'h1010, 1'b1, 1'b0);
    issue(32'h1020, 1'b1, 1'b1);
    chk("t3_stop", 32'(state_o), 32'd3);
    chk("t3_req", 32'(trace_req_off_o), 32'd1);
    issue(32'h1030, 1'b0, 1'b0);
    chk("t3_req_held", 32'(trace_req_off_o), 32'd1);
    chk("t3_count", 32'(count_o), 32'd3);
    cyc();
    trace_enable_i = 1'b0; cyc();
    chk("t3_idle", 32'(state_o), 32'd0);
    chk("t3_req_off", 32'(trace_req_off_o), 32'd0);
    trace_enable_i = 1'b1; cyc();
    chk("t3_rearm_count", 32'(count_o), 32'd0);
    chk("t3_rearm_state", 32'(state_o), 32'd1);

    // 4: threshold 1 from ARMED, then an inverted range
    cfg_stop_after_i = 16'd1;
    exp_cnt = 0;
    issue(32'h1000, 1'b1, 1'b1);
    chk("t4_direct_stop", 32'(state_o), 32'd3);
    cyc();
    trace_enable_i = 1'b0; cyc();
    cfg_stop_after_i = '0; set_range0(32'h2000, 32'h1000);
    trace_enable_i = 1'b1; cyc();
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) issue(t4_addr[i], 1'b0, 1'b0);
    cyc();
    chk("t4_inv_count", 32'(count_o), 32'd0);
    chk("t4_inv_state", 32'(state_o), 32'd1);

    // 5: reset while in STOP
    cfg_range_en_i = '0; cfg_stop_after_i = 16'd2;
    exp_cnt = 0;
    issue(32'h40, 1'b1, 1'b0);
    issue(32'h44, 1'b1, 1'b1);
    chk("t5_req", 32'(trace_req_off_o), 32'd1);
    cyc();
    rst_i = 1'b1; cyc();
    chk("t5_qual", 32'(qualified_o), 32'd0);
    chk("t5_req_rst", 32'(trace_req_off_o), 32'd0);
    chk("t5_count", 32'(count_o), 32'd0);
    chk("t5_state", 32'(state_o), 32'd0);
    rst_i = 1'b0; cyc();
    chk("t5_armed", 32'(state_o), 32'd1);

`ifdef TRDB_FILTER_PRIV_EN
    // 6: privilege mask permits only priv 3
    cfg_stop_after_i = '0; cfg_priv_mask_i = 4'b1000;
    exp_cnt = 0;
    priv_i = 2'd0; issue(32'h80, 1'b0, 1'b0);
    priv_i = 2'd3; issue(32'h84, 1'b1, 1'b0);
    cyc();
    chk("t6_count", 32'(count_o), 32'd1);
`endif

    cyc(); cyc();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trdb_filter.md
Name: trdb_filter

Overview:
- Qualification stage that sits directly upstream of the trace register block and drives that block's `trace_req_off` input.
- Decides, per retired instruction, whether it is traced, using:
  - the current trace enable,
  - programmable address ranges,
  - an optional stop-after-N-instructions counter.
- When the stop condition is met, it raises a trace-off request and holds it until tracing is observed disabled.
- The qualified-instruction strobe feeds the packet emitter.

Parameters:
- ADDR_W, 32, width of instruction address and range bounds.
- NUM_RANGES, 2, number of address-range comparators.
- CNT_W, 16, width of qualified-instruction counter and stop threshold.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- trace_enable_i  in  1  current trace enable from the trace register block.
- inst_valid_i  in  1  one instruction retired this cycle.
- iaddr_i  in  ADDR_W  address of the retired instruction.
- cfg_range_en_i  in  NUM_RANGES  per-range enable.
- cfg_lo_i  in  NUM_RANGES*ADDR_W  inclusive lower bounds; range k at [k*ADDR_W +: ADDR_W].
- cfg_hi_i  in  NUM_RANGES*ADDR_W  inclusive upper bounds, same packing as cfg_lo_i.
- cfg_stop_after_i  in  CNT_W  qualified-instruction limit; 0 disables the limit.
- qualified_o  out  1  previous-cycle instruction is traced.
- trace_req_off_o  out  1  level request to stop tracing; its rising edge is consumed downstream.
- count_o  out  CNT_W  qualified instructions since arming.
- state_o  out  2  FSM state, for debug.

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - qualified_o = 0
  - trace_req_off_o = 0
  - count_o = 0
  - state = IDLE
- Reset mid-operation: all of the above take their reset values on the next edge, including a trace_req_off_o that is currently asserted.
- Range match k: cfg_range_en_i[k] && lo_k <= iaddr_i <= hi_k.
  - Comparison is unsigned and inclusive.
  - lo_k > hi_k never matches.
  - lo_k == hi_k matches exactly one address.
- in_range: OR of all range matches. If cfg_range_en_i == 0, in_range = 1 (filter bypass).
- hit: inst_valid_i && trace_enable_i && in_range && (state == ARMED || state == TRACING).
- State encoding: IDLE=0, ARMED=1, TRACING=2, STOP=3. Transitions are evaluated in priority order:
  - Any state, trace_enable_i == 0 → IDLE. trace_req_off_o deasserts on that edge.
  - IDLE, trace_enable_i == 1 → ARMED. count_o is cleared to 0 on that edge.
  - ARMED, hit → TRACING.
  - ARMED or TRACING, hit and cfg_stop_after_i != 0 and (count_o + 1) >= cfg_stop_after_i → STOP.
    - This takes precedence over ARMED → TRACING.
    - A threshold of 1 therefore goes ARMED → STOP directly.
  - TRACING, out-of-range instructions: stays in TRACING; qualified_o = 0 for those instructions.
  - STOP holds until trace_enable_i == 0.
- Outputs and latency:
  - qualified_o is registered: qualified_o(t+1) = hit(t). One-cycle latency; high for exactly one cycle per hit.
  - count_o increments on each hit and saturates at 2^CNT_W-1 (no wrap). Saturation is allowed only while the limit is disabled, i.e. cfg_stop_after_i == 0.
  - trace_req_off_o = (state == STOP), registered.
    - Rises in the same cycle as qualified_o for the N-th hit.
    - Held high until trace_enable_i falls; the downstream edge detector needs a clean rising edge.
  - No hit is generated in STOP or IDLE, even if inst_valid_i and in_range are both true.
- Configuration:
  - cfg_* inputs are sampled every cycle; changes take effect on the next hit evaluation.
  - Lowering cfg_stop_after_i below count_o while in TRACING causes STOP on the next hit.

Optional Feature:
- Macro TRDB_FILTER_PRIV_EN.
- Defined:
  - Adds port priv_i (in, 2, privilege of the retired instruction).
  - Adds port cfg_priv_mask_i (in, 4, bit p permits privilege p).
  - hit additionally requires cfg_priv_mask_i[priv_i].
  - Reset and FSM behaviour are otherwise unchanged.
- Undefined:
  - These ports do not exist.
  - All privileges qualify.

Test Plan:
1. Reset, then trace_enable_i=1, cfg_range_en_i=0, 5 consecutive valid instructions → state IDLE→ARMED→TRACING; qualified_o high 5 cycles, delayed 1 cycle from inst_valid_i; count_o=5; trace_req_off_o=0.
2. Range 0 = [0x1000,0x10FF] enabled; addresses 0x0FFC, 0x1000, 0x10FF, 0x1100 → qualified only for 0x1000 and 0x10FF; count_o=2; bounds confirmed inclusive.
3. cfg_stop_after_i=3, in-range stream → third hit gives qualified_o=1 and trace_req_off_o=1 in the same cycle; 4th instruction unqualified; trace_req_off_o held; trace_enable_i=0 → IDLE, trace_req_off_o=0 next cycle; re-enable → count_o=0.
4. cfg_stop_after_i=1 from ARMED → first hit goes directly to STOP (state_o=3). Separately, lo=0x2000, hi=0x1000 → no qualification for any address.
5. Assert rst_i while in STOP with trace_req_off_o high → next cycle all outputs 0 and state IDLE, even though trace_enable_i=1; the following cycle state is ARMED.
6. With TRDB_FILTER_PRIV_EN, cfg_priv_mask_i=4'b1000, instructions at priv 0 and 3 → only the priv-3 instruction is qualified.
